// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-4 stream dispatch controller.
package demux_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } dispatch_state_t;

    function automatic logic [NCH-1:0] onehot4(input logic [SELW-1:0] sel);
        logic [NCH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Stream bus between one producer, the dispatch controller and four sinks.
interface demux_dispatch_ctrl_if
    import demux_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CNTW = 8
);
    logic            mode;
    logic [SELW-1:0] in_sel;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic [NCH-1:0]  out_valid;
    logic [NCH-1:0]  out_ready;
    logic [SELW-1:0] rr_ptr;
    logic [CNTW-1:0] xfer_cnt;

    modport master (
        output mode, in_sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, xfer_cnt
    );

    modport slave (
        input  mode, in_sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, xfer_cnt
    );
endinterface

// File: rtl/rr_ptr4.sv
// Two-bit round-robin channel pointer; wraps 3 -> 0 on each enabled step.
module rr_ptr4
    import demux_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [SELW-1:0] ptr
);
    logic [SELW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = inc ? ptr_q + SELW'(1) : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/demux_dispatch_ctrl.sv
// One-entry buffered 1-to-4 stream demultiplexer, steered or round-robin,
// with pass-through refill so a ready sink sustains one word per cycle.
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input logic                  clk,
    input logic                  rst,
    demux_dispatch_ctrl_if.slave bus
);
    dispatch_state_t state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SELW-1:0] tgt_q, tgt_d;
    logic [NCH-1:0]  valid_q, valid_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] next_tgt;
    logic            in_ready;
    logic            accept;
    logic            xfer;

    rr_ptr4 u_rr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (accept & bus.mode),
        .ptr (rr_ptr)
    );

    // Refill is allowed in the same cycle the held word leaves.
    assign in_ready = ~rst & ((state_q == EMPTY) | bus.out_ready[tgt_q]);
    assign accept   = bus.in_valid & in_ready;
    assign xfer     = valid_q[tgt_q] & bus.out_ready[tgt_q];
    assign next_tgt = bus.mode ? rr_ptr : bus.in_sel;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        cnt_d   = xfer ? cnt_q + CNTW'(1) : cnt_q;
        if (xfer) begin
            state_d = EMPTY;
            valid_d = '0;
        end
        if (accept) begin
            state_d = FULL;
            data_d  = bus.in_data;
            tgt_d   = next_tgt;
            valid_d = onehot4(next_tgt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            tgt_q   <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.rr_ptr    = rr_ptr;
    assign bus.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: directed scenarios plus a random run against
// a word-level model of the holding buffer; a CNTW=2 copy shadows the main DUT.
module tb_demux_dispatch_ctrl;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_dispatch_ctrl_if #(.DW(8), .CNTW(8)) bif ();
    demux_dispatch_ctrl_if #(.DW(8), .CNTW(2)) sif ();

    assign sif.mode      = bif.mode;
    assign sif.in_sel    = bif.in_sel;
    assign sif.in_data   = bif.in_data;
    assign sif.in_valid  = bif.in_valid;
    assign sif.out_ready = bif.out_ready;

    demux_dispatch_ctrl #(.DW(8), .CNTW(8)) dut       (.clk(clk), .rst(rst), .bus(bif));
    demux_dispatch_ctrl #(.DW(8), .CNTW(2)) dut_small (.clk(clk), .rst(rst), .bus(sif));

    int n_cmp = 0;
    int n_fail = 0;

    // Model: the buffer is either empty or holds one (word, channel) pair.
    bit         m_full;
    logic [7:0] m_data;
    int         m_tgt;
    int         m_rr;
    int         m_cnt;

    function automatic logic [3:0] exp_valid();
        return m_full ? 4'(1 << m_tgt) : 4'h0;
    endfunction

    function automatic logic exp_ready();
        return !rst && (!m_full || bif.out_ready[m_tgt]);
    endfunction

    task automatic model_clear();
        m_full = 0; m_data = 8'h00; m_tgt = 0; m_rr = 0; m_cnt = 0;
    endtask

    task automatic drive(input bit md, input logic [1:0] sel, input logic [7:0] d,
                         input bit v, input logic [3:0] ord);
        @(negedge clk);
        bif.mode = md; bif.in_sel = sel; bif.in_data = d; bif.in_valid = v; bif.out_ready = ord;
        #1;
    endtask

    task automatic advance();
        bit acc, xf;
        acc = bif.in_valid && exp_ready();
        xf  = m_full && bif.out_ready[m_tgt];
        if (rst) model_clear();
        else begin
            if (xf) begin m_cnt++; m_full = 0; end
            if (acc) begin
                m_full = 1;
                m_data = bif.in_data;
                m_tgt  = bif.mode ? m_rr : int'(bif.in_sel);
                if (bif.mode) m_rr = (m_rr + 1) % 4;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; model_clear();
        drive(0, 2'd0, 8'h00, 0, 4'h0);
        n_cmp++; if (bif.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 0", bif.in_ready); end
        n_cmp++; if (bif.out_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %h want 0", bif.out_valid); end
        n_cmp++; if (bif.out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h want 00", bif.out_data); end
        n_cmp++; if (bif.rr_ptr !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_rr_ptr: got %0d want 0", bif.rr_ptr); end
        n_cmp++; if (bif.xfer_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_xfer_cnt: got %0d want 0", bif.xfer_cnt); end
        @(negedge clk); rst = 0; #1;
        n_cmp++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_in_ready: got %b want 1", bif.in_ready); end

        drive(1, 2'd0, 8'h3C, 1, 4'hF); advance();
        drive(1, 2'd0, 8'hA5, 1, 4'hF); advance();
        drive(0, 2'd0, 8'h00, 0, 4'h0);
        n_cmp++; if (bif.out_valid !== 4'h2) begin n_fail++; $display("[TB] FAIL prereset_valid: got %h want 2", bif.out_valid); end
        n_cmp++; if (bif.out_data !== 8'hA5) begin n_fail++; $display("[TB] FAIL prereset_data: got %h want a5", bif.out_data); end
        n_cmp++; if (bif.rr_ptr !== 2'd2) begin n_fail++; $display("[TB] FAIL prereset_rr: got %0d want 2", bif.rr_ptr); end
        n_cmp++; if (bif.xfer_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL prereset_cnt: got %0d want 1", bif.xfer_cnt); end

        // Assert reset between edges: the clear must not wait for a clock.
        #2 rst = 1; model_clear(); #1;
        n_cmp++; if (bif.out_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL midreset_valid: got %h want 0", bif.out_valid); end
        n_cmp++; if (bif.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_in_ready: got %b want 0", bif.in_ready); end
        n_cmp++; if (bif.rr_ptr !== 2'd0) begin n_fail++; $display("[TB] FAIL midreset_rr: got %0d want 0", bif.rr_ptr); end
        n_cmp++; if (bif.xfer_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL midreset_cnt: got %0d want 0", bif.xfer_cnt); end
        bif.out_ready = 4'hF;
        @(posedge clk); @(negedge clk); rst = 0; #1;
        n_cmp++; if (bif.out_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL postreset_valid: got %h want 0", bif.out_valid); end
        n_cmp++; if (bif.xfer_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL postreset_cnt: got %0d want 0", bif.xfer_cnt); end
    endtask

    task automatic test_steered();
        logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] sels  [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
        logic [3:0] expv  [4] = '{4'h8, 4'h1, 4'h4, 4'h2};
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) drive(0, sels[k], words[k], 1, 4'hF);
            else       drive(0, 2'd0, 8'h00, 0, 4'hF);
            n_cmp++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL steer_in_ready[%0d]: got %b want 1", k, bif.in_ready); end
            if (k > 0) begin
                n_cmp++; if (bif.out_valid !== expv[k-1]) begin n_fail++; $display("[TB] FAIL steer_valid[%0d]: got %h want %h", k, bif.out_valid, expv[k-1]); end
                n_cmp++; if (bif.out_data !== words[k-1]) begin n_fail++; $display("[TB] FAIL steer_data[%0d]: got %h want %h", k, bif.out_data, words[k-1]); end
            end
            advance();
        end
        drive(0, 2'd0, 8'h00, 0, 4'hF);
        n_cmp++; if (bif.out_valid !== 4'h0) begin n_fail++; $display("[TB] FAIL steer_drained: got %h want 0", bif.out_valid); end
        n_cmp++; if (bif.xfer_cnt !== 8'd4) begin n_fail++; $display("[TB] FAIL steer_cnt: got %0d want 4", bif.xfer_cnt); end
        n_cmp++; if (bif.rr_ptr !== 2'd0) begin n_fail++; $display("[TB] FAIL steer_rr_untouched: got %0d want 0", bif.rr_ptr); end
    endtask

    task automatic test_round_robin();
        logic [7:0] words [6];
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                words[k] = 8'($urandom);
                drive(1, 2'($urandom), words[k], 1, 4'hF);
            end else drive(1, 2'd0, 8'h00, 0, 4'hF);
            if (k > 0) begin
                n_cmp++; if (bif.out_valid !== 4'(1 << ((k - 1) % 4))) begin n_fail++; $display("[TB] FAIL rr_channel[%0d]: got %h want %h", k, bif.out_valid, 4'(1 << ((k - 1) % 4))); end
                n_cmp++; if (bif.out_data !== words[k-1]) begin n_fail++; $display("[TB] FAIL rr_data[%0d]: got %h want %h", k, bif.out_data, words[k-1]); end
            end
            advance();
        end
        drive(1, 2'd0, 8'h00, 0, 4'hF);
        n_cmp++; if (bif.rr_ptr !== 2'd2) begin n_fail++; $display("[TB] FAIL rr_end_ptr: got %0d want 2", bif.rr_ptr); end
        n_cmp++; if (bif.xfer_cnt !== 8'd10) begin n_fail++; $display("[TB] FAIL rr_cnt: got %0d want 10", bif.xfer_cnt); end
    endtask

    task automatic test_backpressure();
        int cnt0;
        drive(0, 2'd2, 8'h5A, 1, 4'hF); advance();
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd2, 8'h77, 1, 4'b1011);
            n_cmp++; if (bif.out_valid !== 4'h4) begin n_fail++; $display("[TB] FAIL bp_valid[%0d]: got %h want 4", i, bif.out_valid); end
            n_cmp++; if (bif.out_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL bp_data[%0d]: got %h want 5a", i, bif.out_data); end
            n_cmp++; if (bif.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, bif.in_ready); end
            n_cmp++; if (bif.xfer_cnt !== 8'(cnt0)) begin n_fail++; $display("[TB] FAIL bp_cnt[%0d]: got %0d want %0d", i, bif.xfer_cnt, cnt0); end
            advance();
        end
        drive(0, 2'd2, 8'h77, 1, 4'hF);
        n_cmp++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b want 1", bif.in_ready); end
        advance();
        drive(0, 2'd0, 8'h00, 0, 4'hF);
        n_cmp++; if (bif.out_valid !== 4'h4 || bif.out_data !== 8'h77) begin n_fail++; $display("[TB] FAIL bp_refill: got %h/%h want 4/77", bif.out_valid, bif.out_data); end
        n_cmp++; if (bif.xfer_cnt !== 8'(cnt0 + 1)) begin n_fail++; $display("[TB] FAIL bp_single_xfer: got %0d want %0d", bif.xfer_cnt, cnt0 + 1); end
        advance();
    endtask

    task automatic test_mode_change();
        int rr0;
        drive(0, 2'd1, 8'hC3, 1, 4'h0); advance();
        rr0 = m_rr;
        for (int i = 0; i < 2; i++) begin
            drive(1, 2'd3, 8'h99, 0, 4'b1000);
            n_cmp++; if (bif.out_valid !== 4'h2 || bif.out_data !== 8'hC3) begin n_fail++; $display("[TB] FAIL mc_hold[%0d]: got %h/%h want 2/c3", i, bif.out_valid, bif.out_data); end
            n_cmp++; if (bif.rr_ptr !== 2'(rr0)) begin n_fail++; $display("[TB] FAIL mc_rr_hold[%0d]: got %0d want %0d", i, bif.rr_ptr, rr0); end
            advance();
        end
        drive(1, 2'd3, 8'h99, 0, 4'hF); advance();
        drive(1, 2'd3, 8'hE7, 1, 4'hF);
        n_cmp++; if (bif.out_valid !== 4'h0 || bif.rr_ptr !== 2'(rr0)) begin n_fail++; $display("[TB] FAIL mc_delivered: got %h rr %0d want 0 rr %0d", bif.out_valid, bif.rr_ptr, rr0); end
        advance();
        drive(1, 2'd0, 8'h00, 0, 4'h0);
        n_cmp++; if (bif.out_valid !== 4'(1 << rr0) || bif.out_data !== 8'hE7) begin n_fail++; $display("[TB] FAIL mc_next_rr: got %h/%h want %h/e7", bif.out_valid, bif.out_data, 4'(1 << rr0)); end
        n_cmp++; if (bif.rr_ptr !== 2'((rr0 + 1) % 4)) begin n_fail++; $display("[TB] FAIL mc_rr_step: got %0d want %0d", bif.rr_ptr, (rr0 + 1) % 4); end
        drive(1, 2'd0, 8'h00, 0, 4'hF); advance();
    endtask

    task automatic test_counter_wrap();
        logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int k = 0; k <= 6; k++) begin
            drive(0, 2'($urandom), 8'($urandom), k < 5, 4'hF);
            if (k >= 2) begin
                n_cmp++; if (sif.xfer_cnt !== seq[k-2]) begin n_fail++; $display("[TB] FAIL cnt_wrap[%0d]: got %0d want %0d", k - 2, sif.xfer_cnt, seq[k-2]); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [3:0] ord;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            ord = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            drive(1'($urandom), 2'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, ord);
            n_cmp++; if (bif.out_valid !== exp_valid()) begin n_fail++; $display("[TB] FAIL rand_valid@%0d: got %h want %h", i, bif.out_valid, exp_valid()); end
            n_cmp++; if (!$onehot0(bif.out_valid)) begin n_fail++; $display("[TB] FAIL rand_onehot@%0d: got %h want onehot0", i, bif.out_valid); end
            n_cmp++; if (bif.in_ready !== exp_ready()) begin n_fail++; $display("[TB] FAIL rand_ready@%0d: got %b want %b", i, bif.in_ready, exp_ready()); end
            if (m_full) begin
                n_cmp++; if (bif.out_data !== m_data) begin n_fail++; $display("[TB] FAIL rand_data@%0d: got %h want %h", i, bif.out_data, m_data); end
            end
            n_cmp++; if (bif.rr_ptr !== 2'(m_rr)) begin n_fail++; $display("[TB] FAIL rand_rr@%0d: got %0d want %0d", i, bif.rr_ptr, m_rr); end
            n_cmp++; if (bif.xfer_cnt !== 8'(m_cnt % 256)) begin n_fail++; $display("[TB] FAIL rand_cnt@%0d: got %0d want %0d", i, bif.xfer_cnt, m_cnt % 256); end
            n_cmp++; if (sif.xfer_cnt !== 2'(m_cnt % 4)) begin n_fail++; $display("[TB] FAIL rand_cnt2@%0d: got %0d want %0d", i, sif.xfer_cnt, m_cnt % 4); end
            advance();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bif.mode = 0; bif.in_sel = 0; bif.in_data = 0; bif.in_valid = 0; bif.out_ready = 0;
        test_reset();
        test_steered();
        test_round_robin();
        test_backpressure();
        test_mode_change();
        test_counter_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
